// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
//   Shared definitions for the data-memory arbiter.
//   - DATA_W       : data width on every data port (32).
//   - MAX_WAIT_DEF : default number of consecutive cycles the aux requester may
//                    be denied before its access is forced through.
//   - ret_state_e  : encoding of the read-return state, i.e. which requester
//                    owns the data the memory presents in the next cycle.
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int DATA_W       = 32;
    localparam int MAX_WAIT_DEF = 4;

    typedef enum logic [1:0] {
        RET_NONE = 2'd0,
        RET_PIPE = 2'd1,
        RET_AUX  = 2'd2
    } ret_state_e;

endpackage : dmem_pkg

// File: rtl/dmem_starve_cnt.sv
// -----------------------------------------------------------------------------
// dmem_starve_cnt
//   Counts consecutive cycles in which the aux requester is waiting without
//   being granted, and raises force_aux once it has waited MAX_WAIT cycles so
//   the arbiter can push the aux access ahead of the pipeline.
//
//   Parameters:
//     MAX_WAIT  - denial limit, 1..15 (the counter is 4 bits wide).
//
//   Ports:
//     clk       in   clock, rising edge
//     rst       in   asynchronous active-high reset
//     a_req     in   aux request pending
//     a_gnt     in   aux access issued this cycle
//     force_aux out  aux must be issued this cycle (combinational)
// -----------------------------------------------------------------------------
module dmem_starve_cnt
    import dmem_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic a_req,
    input  logic a_gnt,
    output logic force_aux
);

    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0] wait_cnt_q;
    logic [3:0] wait_cnt_d;

    // A grant always restarts the count; otherwise a waiting request climbs
    // towards MAX_WAIT and sticks there until it is served.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (a_gnt) begin
            wait_cnt_d = 4'd0;
        end else if (a_req && (wait_cnt_q != MAX_WAIT_C)) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= 4'd0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Depends only on a_req and registered state, so the grant mux that
    // consumes it forms no combinational loop through a_gnt.
    assign force_aux = a_req && (wait_cnt_q == MAX_WAIT_C);

endmodule : dmem_starve_cnt

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port synchronous data memory between the pipeline MEM
//   stage and an auxiliary master (loader / debug port). The pipeline has
//   priority; a starvation counter forces a waiting aux access through after
//   MAX_WAIT denials, stalling the pipeline for that single cycle. Read data
//   coming back from the memory one cycle later is steered to whichever
//   requester issued the read.
//
//   Optional build macro: DMEM_ARB_PERF_EN
//     Adds stall_cnt / aux_cnt outputs: saturating counts of stall cycles and
//     aux grants, both cleared by RST.
//
//   Parameters:
//     ADDR_W    - address width on all ports (default 32)
//     MAX_WAIT  - aux denial limit before forcing, 1..15 (default 4)
//
//   Ports:
//     CLK, RST            clock (rising edge), asynchronous active-high reset
//     p_rd, p_wr          pipeline MemRead / MemWrite (write wins if both)
//     p_addr, p_wdata     pipeline address / write data
//     p_rdata             pipeline read data, cycle after the read, else 0
//     p_stall             pipeline access denied this cycle
//     a_req, a_we         aux request / write-not-read, held until a_gnt
//     a_addr, a_wdata     aux address / write data
//     a_gnt               aux access issued this cycle
//     a_rvalid, a_rdata   aux read data (cycle after a read grant), else 0
//     mem_en, mem_we      memory enable / write enable
//     mem_addr, mem_wdata memory address / write data (0 when idle)
//     mem_rdata           memory read data, one-cycle latency
//     stall_cnt, aux_cnt  performance counters (DMEM_ARB_PERF_EN only)
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    // pipeline MEM stage
    input  logic              p_rd,
    input  logic              p_wr,
    input  logic [ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0] p_wdata,
    output logic [DATA_W-1:0] p_rdata,
    output logic              p_stall,
    // auxiliary master
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    // data memory macro
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       aux_cnt
`endif
);

    logic       p_act;
    logic       force_aux;
    logic       pipe_issue;
    logic       aux_issue;
    ret_state_e ret_q;
    ret_state_e ret_d;

    dmem_starve_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk       (CLK),
        .rst       (RST),
        .a_req     (a_req),
        .a_gnt     (a_gnt),
        .force_aux (force_aux)
    );

    // Grant mux. A forced aux access pre-empts the pipeline; otherwise the
    // pipeline wins whenever it is active and aux only fills idle slots.
    always_comb begin
        p_act      = p_rd | p_wr;
        aux_issue  = a_req & (force_aux | ~p_act);
        pipe_issue = p_act & ~force_aux;
        p_stall    = force_aux & p_act;
        a_gnt      = aux_issue;
        mem_en     = aux_issue | pipe_issue;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        ret_d      = RET_NONE;
        if (pipe_issue) begin
            mem_we    = p_wr;
            mem_addr  = p_addr;
            mem_wdata = p_wdata;
            // With both p_rd and p_wr set the access is a pure write, so no
            // return is scheduled.
            if (p_rd && !p_wr) begin
                ret_d = RET_PIPE;
            end
        end else if (aux_issue) begin
            mem_we    = a_we;
            mem_addr  = a_addr;
            mem_wdata = a_wdata;
            if (!a_we) begin
                ret_d = RET_AUX;
            end
        end
    end

    // Return-owner state: remembers who issued the read whose data the
    // memory presents next cycle. Reset drops any pending return.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ret_q <= RET_NONE;
        end else begin
            ret_q <= ret_d;
        end
    end

    // Read data is gated to zero for whichever requester does not own it.
    always_comb begin
        p_rdata  = '0;
        a_rvalid = 1'b0;
        a_rdata  = '0;
        case (ret_q)
            RET_PIPE: begin
                p_rdata = mem_rdata;
            end
            RET_AUX: begin
                a_rvalid = 1'b1;
                a_rdata  = mem_rdata;
            end
            default: begin
            end
        endcase
    end

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;
    logic [31:0] aux_cnt_q;
    logic [31:0] aux_cnt_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        aux_cnt_d   = aux_cnt_q;
        if (p_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (a_gnt && (aux_cnt_q != 32'hFFFF_FFFF)) begin
            aux_cnt_d = aux_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= 32'd0;
            aux_cnt_q   <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            aux_cnt_q   <= aux_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign aux_cnt   = aux_cnt_q;
`endif

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter. A small synchronous memory model
//   answers the DUT's memory port; a behavioural reference (integer wait count,
//   pending-return record, shadow memory) predicts every output each cycle.
//   Directed scenarios add literal expectations, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    localparam int ADDR_W   = 32;
    localparam int MAX_WAIT = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        p_rd, p_wr;
    logic [31:0] p_addr, p_wdata, p_rdata;
    logic        p_stall;
    logic        a_req, a_we;
    logic [31:0] a_addr, a_wdata;
    logic        a_gnt, a_rvalid;
    logic [31:0] a_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0] stall_cnt, aux_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    dmem_arbiter #(
        .ADDR_W   (ADDR_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .p_rd      (p_rd),
        .p_wr      (p_wr),
        .p_addr    (p_addr),
        .p_wdata   (p_wdata),
        .p_rdata   (p_rdata),
        .p_stall   (p_stall),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_gnt     (a_gnt),
        .a_rvalid  (a_rvalid),
        .a_rdata   (a_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        ,
        .stall_cnt (stall_cnt),
        .aux_cnt   (aux_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_word(input int a);
        return 32'hA500_0000 | 32'(a);
    endfunction

    // Environment memory: 32 words, one-cycle read latency, junk when idle.
    logic [31:0] env_mem [32];
    bit          env_wr  [32];
    always @(posedge CLK) begin
        if (mem_en && mem_we) begin
            env_mem[mem_addr[4:0]] <= mem_wdata;
            env_wr[mem_addr[4:0]]  <= 1'b1;
        end
        if (mem_en && !mem_we) begin
            mem_rdata <= env_wr[mem_addr[4:0]] ? env_mem[mem_addr[4:0]]
                                                : init_word(int'(mem_addr[4:0]));
        end else begin
            mem_rdata <= $urandom;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural reference ----------------
    int          m_wait;
    int          m_ret;        // 0 none, 1 pipeline, 2 aux
    logic [31:0] m_ret_data;
    logic [31:0] m_mem [32];
    bit          m_gnt, m_stall;
    int          m_stall_cnt, m_aux_cnt;
    bit          t_act, t_frc, t_aux, t_pipe, t_we;
    logic [31:0] t_addr, t_wd;

    initial begin
        for (int i = 0; i < 32; i++) m_mem[i] = init_word(i);
        m_wait = 0; m_ret = 0; m_ret_data = 0; m_gnt = 0; m_stall = 0;
        m_stall_cnt = 0; m_aux_cnt = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                chk("rst_p_rdata", p_rdata, 0);
                chk("rst_a_rvalid", a_rvalid, 0);
                chk("rst_a_rdata", a_rdata, 0);
                chk("rst_p_stall", p_stall, 0);
                chk("rst_a_gnt", a_gnt, 0);
                chk("rst_mem_en", mem_en, 0);
                m_wait = 0; m_ret = 0; m_gnt = 0; m_stall = 0;
                m_stall_cnt = 0; m_aux_cnt = 0;
            end else begin
                t_act  = p_rd | p_wr;
                t_frc  = a_req && (m_wait >= MAX_WAIT);
                t_aux  = a_req && (t_frc || !t_act);
                t_pipe = t_act && !t_aux;
                t_we = 0; t_addr = 0; t_wd = 0;
                if (t_pipe) begin
                    t_we = p_wr; t_addr = p_addr; t_wd = p_wdata;
                end else if (t_aux) begin
                    t_we = a_we; t_addr = a_addr; t_wd = a_wdata;
                end
                chk("p_rdata", p_rdata, (m_ret == 1) ? m_ret_data : 32'd0);
                chk("a_rvalid", a_rvalid, 32'(m_ret == 2));
                chk("a_rdata", a_rdata, (m_ret == 2) ? m_ret_data : 32'd0);
                chk("p_stall", p_stall, 32'(t_frc && t_act));
                chk("a_gnt", a_gnt, 32'(t_aux));
                chk("mem_en", mem_en, 32'(t_aux || t_pipe));
                chk("mem_we", mem_we, 32'(t_we));
                chk("mem_addr", mem_addr, t_addr);
                if (t_we || !(t_aux || t_pipe)) chk("mem_wdata", mem_wdata, t_wd);
`ifdef DMEM_ARB_PERF_EN
                chk("stall_cnt", stall_cnt, 32'(m_stall_cnt));
                chk("aux_cnt", aux_cnt, 32'(m_aux_cnt));
`endif
                m_ret = 0;
                if (t_aux || t_pipe) begin
                    if (t_we) m_mem[t_addr[4:0]] = t_wd;
                    else begin
                        m_ret      = t_pipe ? 1 : 2;
                        m_ret_data = m_mem[t_addr[4:0]];
                    end
                end
                if (t_aux) m_wait = 0;
                else if (a_req && m_wait < MAX_WAIT) m_wait++;
                if (t_frc && t_act) m_stall_cnt++;
                if (t_aux) m_aux_cnt++;
                m_gnt   = t_aux;
                m_stall = t_frc && t_act;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_p(input bit rd, input bit wr, input logic [31:0] ad, input logic [31:0] d);
        p_rd = rd; p_wr = wr; p_addr = ad; p_wdata = d;
    endtask

    task automatic set_a(input bit rq, input bit we, input logic [31:0] ad, input logic [31:0] d);
        a_req = rq; a_we = we; a_addr = ad; a_wdata = d;
    endtask

    task automatic idle();
        set_p(0, 0, 0, 0);
        set_a(0, 0, 0, 0);
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    // Pipeline reads addr 10 back-to-back while aux waits on a read of addr 20.
    task automatic starve_once();
        for (int k = 1; k <= 5; k++) begin
            set_p(1, 0, 10, 0);
            set_a(1, 0, 20, 0);
            @(negedge CLK);
            chk("starve_gnt", a_gnt, 32'(k == 5));
            chk("starve_stall", p_stall, 32'(k == 5));
            if (k >= 2) chk("starve_p_rdata", p_rdata, 7);
            next_cycle();
        end
        set_p(1, 0, 10, 0);
        set_a(0, 0, 0, 0);
        @(negedge CLK);
        chk("starve_after_stall", p_stall, 0);
        chk("starve_a_rvalid", a_rvalid, 1);
        chk("starve_a_rdata", a_rdata, 3);
        chk("starve_p_rdata_gap", p_rdata, 0);
        next_cycle();
        idle();
        @(negedge CLK);
        chk("starve_reread", p_rdata, 7);
        next_cycle();
    endtask

    initial begin
        idle();
        #2 RST = 1'b1;
        #1;
        chk("reset_p_rdata", p_rdata, 0);
        chk("reset_a_rvalid", a_rvalid, 0);
        chk("reset_mem_en", mem_en, 0);
        next_cycle();
        next_cycle();
        RST = 1'b0;

        // pipeline write then read-back
        set_p(0, 1, 10, 7);
        @(negedge CLK);
        chk("pw_stall", p_stall, 0);
        chk("pw_mem_we", mem_we, 1);
        chk("pw_mem_addr", mem_addr, 10);
        next_cycle();
        set_p(1, 0, 10, 0);
        @(negedge CLK);
        chk("pr_stall", p_stall, 0);
        next_cycle();
        idle();
        @(negedge CLK);
        chk("pr_data", p_rdata, 7);
        next_cycle();

        // aux write then read-back with the pipeline idle
        set_a(1, 1, 20, 3);
        @(negedge CLK);
        chk("aw_gnt", a_gnt, 1);
        next_cycle();
        set_a(1, 0, 20, 0);
        @(negedge CLK);
        chk("ar_gnt", a_gnt, 1);
        next_cycle();
        idle();
        @(negedge CLK);
        chk("ar_rvalid", a_rvalid, 1);
        chk("ar_rdata", a_rdata, 3);
        next_cycle();

        // read and write together: write wins, nothing returned
        set_p(1, 1, 30, 32'h55);
        @(negedge CLK);
        chk("rw_mem_we", mem_we, 1);
        next_cycle();
        idle();
        @(negedge CLK);
        chk("rw_no_return", p_rdata, 0);
        next_cycle();
        set_p(1, 0, 30, 0);
        @(negedge CLK);
        next_cycle();
        idle();
        @(negedge CLK);
        chk("rw_readback", p_rdata, 32'h55);
        next_cycle();

        // reset arriving while an aux read return is pending
        set_a(1, 0, 20, 0);
        @(negedge CLK);
        chk("rr_gnt", a_gnt, 1);
        next_cycle();
        idle();
        RST = 1'b1;
        #1;
        chk("rr_async_rvalid", a_rvalid, 0);
        chk("rr_async_rdata", a_rdata, 0);
        chk("rr_async_p_rdata", p_rdata, 0);
        chk("rr_async_mem_en", mem_en, 0);
        next_cycle();
        RST = 1'b0;
        @(negedge CLK);
        chk("rr_no_rvalid", a_rvalid, 0);
        next_cycle();

        // starvation forcing, three times from a fresh reset
        starve_once();
        starve_once();
        starve_once();
`ifdef DMEM_ARB_PERF_EN
        chk("perf_stall_cnt", stall_cnt, 3);
        chk("perf_aux_cnt", aux_cnt, 3);
`endif

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 499) == 0) begin
                idle();
                RST = 1'b1;
                @(negedge CLK);
                next_cycle();
                RST = 1'b0;
            end else begin
                if (!m_stall) begin
                    case ($urandom_range(0, 9))
                        0, 1, 2, 3: set_p(0, 0, 0, 0);
                        4, 5, 6:    set_p(1, 0, $urandom_range(0, 31), $urandom);
                        7, 8:       set_p(0, 1, $urandom_range(0, 31), $urandom);
                        default:    set_p(1, 1, $urandom_range(0, 31), $urandom);
                    endcase
                end
                if (!(a_req && !m_gnt)) begin
                    if ($urandom_range(0, 2) == 0)
                        set_a(1, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom);
                    else
                        set_a(0, 0, 0, 0);
                end
                @(negedge CLK);
                next_cycle();
            end
        end

        idle();
        @(negedge CLK);
        next_cycle();
        @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_dmem_arbiter
